sad_row_aggregator: RTL
=======================

SAD_ROW_AGGREGATOR -- requirements
Module: sad_row_aggregator

Interface
REQ-001 Parameter ELEM, default 64: number of disparity candidates per pixel.
REQ-002 Parameter IN_WIDTH, default 8: width of each per-pixel matching cost.
REQ-003 Parameter DATA_WIDTH, default 8: width of each aggregated SAD output, which feeds the disparity arg-min stage.
REQ-004 Parameter WIN, default 5: horizontal aggregation window in pixels; legal range 2..32.
REQ-005 Parameter SHIFT, default 0: right-shift applied to the window sum before saturation.
REQ-006 Port aclk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port c_en, input, 1 bit: pipeline enable; low stalls the block.
REQ-009 Port i_valid, input, 1 bit: i_cost carries a pixel this cycle.
REQ-010 Port i_sol, input, 1 bit: start of line; qualified by i_valid.
REQ-011 Port i_cost, input, ELEM x IN_WIDTH packed: per-disparity absolute difference for the current pixel; index d is disparity d.
REQ-012 Port o_valid, output, 1 bit: o_sads_data holds a full-window result.
REQ-013 Port o_sads_data, output, ELEM x DATA_WIDTH packed: aggregated SAD per disparity; index d is disparity d.

Function
REQ-014 An accepted sample is defined as a rising edge with rst=0, c_en=1 and i_valid=1.
REQ-015 For each d, the block keeps a WIN-deep history of accepted costs and a running sum S_d of width IN_WIDTH+$clog2(WIN)+1, which never wraps.
REQ-016 A fill counter, saturating at WIN, counts the accepted samples in the current line.
REQ-017 On an accepted sample with i_sol=1, the counter becomes 1, S_d becomes i_cost[d], and all older history entries are treated as empty.
REQ-018 On an accepted sample with i_sol=0 and counter<WIN, S_d becomes S_d+i_cost[d], the counter increments, and nothing is subtracted.
REQ-019 On an accepted sample with i_sol=0 and counter=WIN, S_d becomes S_d+i_cost[d]-oldest_d, where oldest_d is the cost accepted WIN samples earlier; the counter stays at WIN.
REQ-020 o_sads_data and o_valid are registered and update on the same edge as S_d, giving a latency of 1 cycle from an accepted sample.
REQ-021 Each output element is o_sads_data[d] = min(S_d_new >> SHIFT, 2^DATA_WIDTH-1), saturating rather than truncating.
REQ-022 On an accepted sample, o_valid becomes 1 only when the post-update counter equals WIN; otherwise it becomes 0.
REQ-023 When c_en=1 and i_valid=0, o_valid becomes 0, while o_sads_data, the sums, the history and the counter hold.
REQ-024 When c_en=0, every register holds, including o_valid; i_valid, i_sol and i_cost are ignored.
REQ-025 When i_sol=1 and i_valid=0, i_sol has no effect.
REQ-026 Lines shorter than WIN produce no o_valid pulse, and their samples never contribute to the next line's sums.

Reset
REQ-027 When rst=1 at a rising edge, all S_d, all history entries, the counter, o_valid and o_sads_data are cleared to 0, regardless of c_en.
REQ-028 rst asserted mid-line discards the partial window; the first accepted sample after reset is treated as if i_sol=1.

Verification
REQ-029 Defaults (WIN=5, SHIFT=0), c_en=1: i_sol on the first sample, then i_cost all=10 for 7 samples -> o_valid=0 for samples 1-4, then 1 for samples 5-7 with every element = 50.
REQ-030 Ramp test: costs for disparity 0 of 1,2,3,4,5,6,7 -> o_sads_data[0] = 15, 20, 25 on samples 5, 6, 7 (checks the subtraction of the oldest cost).
REQ-031 Saturation test: all costs = 100 for 5 samples -> element = 255 (raw sum 500); then costs = 0 for 5 samples -> sum decays through 400, 300, 200, 100, 0, outputs 255, 255, 200, 100, 0.
REQ-032 Line restart: i_sol asserted on sample 7 of a line of constant costs = 10 -> o_valid=0 for the next 4 accepted samples, then o_valid=1 with value 50 and no carry-over from the previous line.
REQ-033 Stall and bubble test: c_en=0 for 3 cycles mid-window, and separately i_valid=0 gaps -> results are identical to the gap-free run, and o_valid stays held during the c_en=0 stall and 0 during bubbles.
REQ-034 Reset test: rst pulsed for 1 cycle after 3 samples, then 5 samples of cost 10 -> all outputs 0 the cycle after reset, and the first o_valid arrives on the 5th post-reset sample with value 50.

Source files
------------

// File: rtl/sad_row_aggregator_if.sv
// Pixel-stream bundle for the SAD row aggregator: per-disparity cost vector
// in, per-disparity windowed SAD vector out.
interface sad_row_aggregator_if #(
    parameter int ELEM       = 64,
    parameter int IN_WIDTH   = 8,
    parameter int DATA_WIDTH = 8
);
    // i_valid marks a pixel on i_cost; i_sol is meaningful only with i_valid.
    // There is no backpressure: a sample is taken on any enabled edge with i_valid=1.
    logic                                 i_valid;
    logic                                 i_sol;
    logic [ELEM-1:0][IN_WIDTH-1:0]        i_cost;
    logic                                 o_valid;
    logic [ELEM-1:0][DATA_WIDTH-1:0]      o_sads_data;

    modport master (
        output i_valid, i_sol, i_cost,
        input  o_valid, o_sads_data
    );

    modport slave (
        input  i_valid, i_sol, i_cost,
        output o_valid, o_sads_data
    );
endinterface

// File: rtl/sad_row_aggregator.sv
// Horizontal box-filter of matching costs: per disparity, a running sum over
// the last WIN pixels of the current line, shifted and saturated to DATA_WIDTH.
module sad_row_aggregator #(
    parameter int ELEM       = 64,
    parameter int IN_WIDTH   = 8,
    parameter int DATA_WIDTH = 8,
    parameter int WIN        = 5,
    parameter int SHIFT      = 0
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic                  c_en,
    sad_row_aggregator_if.slave   bus
);
    localparam int SW    = IN_WIDTH + $clog2(WIN) + 1;
    localparam int CW    = ((SW > DATA_WIDTH) ? SW : DATA_WIDTH) + 1;
    localparam int CNT_W = $clog2(WIN + 1);
    localparam logic [CNT_W-1:0]      WIN_C = CNT_W'(WIN);
    localparam logic [DATA_WIDTH-1:0] DMAX  = '1;

    logic [IN_WIDTH-1:0]             r_hist [WIN][ELEM];
    logic [SW-1:0]                   r_sum  [ELEM];
    logic [CNT_W-1:0]                r_cnt;
    logic                            r_valid;
    logic [ELEM-1:0][DATA_WIDTH-1:0] r_data;

    logic                            w_accept;
    logic                            w_start;
    logic                            w_full;
    logic [CNT_W-1:0]                w_cnt_next;
    logic [SW-1:0]                   w_sum_next [ELEM];
    logic [CW-1:0]                   w_ext      [ELEM];
    logic [DATA_WIDTH-1:0]           w_sat      [ELEM];

    // A zero count only occurs after reset, so that sample opens a fresh line.
    assign w_accept   = c_en & bus.i_valid;
    assign w_start    = bus.i_sol | (r_cnt == '0);
    assign w_full     = (r_cnt == WIN_C);
    assign w_cnt_next = w_start ? CNT_W'(1) : (w_full ? WIN_C : r_cnt + CNT_W'(1));

    always_comb begin
        for (int d = 0; d < ELEM; d++) begin
            w_sum_next[d] = r_sum[d];
            w_ext[d]      = '0;
            w_sat[d]      = '0;
            if (w_start) begin
                w_sum_next[d] = SW'(bus.i_cost[d]);
            end else if (w_full) begin
                w_sum_next[d] = r_sum[d] + SW'(bus.i_cost[d]) - SW'(r_hist[WIN-1][d]);
            end else begin
                w_sum_next[d] = r_sum[d] + SW'(bus.i_cost[d]);
            end
            w_ext[d] = CW'(w_sum_next[d] >> SHIFT);
            w_sat[d] = (w_ext[d] > CW'(DMAX)) ? DMAX : DATA_WIDTH'(w_ext[d]);
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            for (int d = 0; d < ELEM; d++) begin
                r_sum[d] <= '0;
                for (int k = 0; k < WIN; k++) begin
                    r_hist[k][d] <= '0;
                end
            end
        end else if (w_accept) begin
            r_cnt   <= w_cnt_next;
            r_valid <= (w_cnt_next == WIN_C);
            for (int d = 0; d < ELEM; d++) begin
                r_sum[d]     <= w_sum_next[d];
                r_data[d]    <= w_sat[d];
                r_hist[0][d] <= bus.i_cost[d];
                // A new line empties the older history so nothing leaks across lines.
                for (int k = 1; k < WIN; k++) begin
                    r_hist[k][d] <= w_start ? '0 : r_hist[k-1][d];
                end
            end
        end else if (c_en) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.o_valid     = r_valid;
    assign bus.o_sads_data = r_data;
endmodule
